// File: rtl/reel_controller_pkg.sv
// Shared encodings and thresholds for the fishing-reel controller.
// Level filtering and step selection helpers live here so every file agrees on them.
package reel_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_REEL = 2'd2,
        ST_COOL = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        LVL_NONE = 2'd0,
        LVL_SLOW = 2'd1,
        LVL_FAST = 2'd2
    } level_e;

    localparam logic [2:0] STEP_NONE = 3'd0;
    localparam logic [2:0] STEP_SLOW = 3'd2;
    localparam logic [2:0] STEP_FAST = 3'd4;

    localparam logic [3:0] AVG_SLOW = 4'd9;
    localparam logic [3:0] AVG_FAST = 4'd10;

    function automatic logic [1:0] raw_level(input logic [3:0] avg);
        if (avg >= AVG_FAST) begin
            return LVL_FAST;
        end else if (avg == AVG_SLOW) begin
            return LVL_SLOW;
        end
        return LVL_NONE;
    endfunction

    // Cooldown caps the climb rate at the slow step even when reeling fast.
    function automatic logic [2:0] step_for(input state_e st, input logic [1:0] lvl);
        logic [2:0] s;
        s = STEP_NONE;
        if (st == ST_REEL) begin
            if (lvl == LVL_FAST) begin
                s = STEP_FAST;
            end else if (lvl == LVL_SLOW) begin
                s = STEP_SLOW;
            end
        end else if (st == ST_COOL) begin
            if (lvl != LVL_NONE) begin
                s = STEP_SLOW;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/reel_controller_game_tick_gen.sv
// Free-running divider producing the one-cycle game tick.
// The pulse is a decode of the counter, so it lines up with the last count.
module game_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic rst,
    output logic game_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign game_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/reel_controller.sv
// Reel controller: filters reel speed into a level and turns it into per-tick
// line-raise steps, with a strike delay and a fatigue cooldown.
module reel_controller
    import reel_controller_pkg::*;
#(
    parameter int TICK_DIV   = 833333,
    parameter int ARM_TICKS  = 30,
    parameter int HOLD_TICKS = 8,
    parameter int MAX_BURST  = 240,
    parameter int COOL_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] reel,
    input  logic       reel_valid,
    input  logic       catch_active,
    output logic       game_tick,
    output logic       step_valid,
    output logic [2:0] step,
    output logic [1:0] level,
    output logic [1:0] state
);

    localparam int AW = $clog2(ARM_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int KW = $clog2(COOL_TICKS + 1);

    localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_TICKS - 1);
    localparam logic [AW-1:0] ARM_MAX    = AW'(ARM_TICKS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_TICKS);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
    localparam logic [KW-1:0] COOL_LAST  = KW'(COOL_TICKS - 1);
    localparam logic [KW-1:0] COOL_MAX   = KW'(COOL_TICKS);

    state_e        state_q, state_d;
    logic [3:0]    buf_q [4];
    logic [5:0]    sum;
    logic [3:0]    avg;
    logic [1:0]    raw;
    logic [1:0]    level_q, level_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] arm_q, arm_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [KW-1:0] cool_q, cool_d;
    logic [2:0]    step_q, step_d;
    logic          reel_unused;

    assign reel_unused = ^reel[4:0];

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .game_tick (game_tick)
    );

    // Four-deep sample history; the sensor keeps filling it even while idle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_buf
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        buf_q[gi] <= '0;
                    end else if (reel_valid) begin
                        buf_q[gi] <= reel[8:5];
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        buf_q[gi] <= '0;
                    end else if (reel_valid) begin
                        buf_q[gi] <= buf_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign sum = 6'(buf_q[0]) + 6'(buf_q[1]) + 6'(buf_q[2]) + 6'(buf_q[3]);
    assign avg = 4'(sum >> 2);
    assign raw = raw_level(avg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!catch_active) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARM;
                ST_ARM:  if (game_tick && arm_q == ARM_LAST) state_d = ST_REEL;
                ST_REEL: if (game_tick && level_q == LVL_FAST && burst_q == BURST_LAST) state_d = ST_COOL;
                ST_COOL: if (game_tick && cool_q == COOL_LAST) state_d = ST_REEL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        arm_d   = arm_q;
        burst_d = burst_q;
        cool_d  = cool_q;
        case (state_q)
            ST_IDLE: arm_d = '0;
            ST_ARM:  if (game_tick && arm_q != ARM_MAX) arm_d = arm_q + 1'b1;
            ST_REEL: begin
                if (game_tick) begin
                    if (level_q != LVL_FAST) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            ST_COOL: if (game_tick && cool_q != COOL_MAX) cool_d = cool_q + 1'b1;
            default: arm_d = '0;
        endcase
        if (state_d == ST_COOL && state_q != ST_COOL) cool_d = '0;
        if (state_d == ST_REEL && state_q != ST_REEL) burst_d = '0;
        if (state_d == ST_IDLE) begin
            arm_d   = '0;
            burst_d = '0;
            cool_d  = '0;
        end
    end

    // Fast attack, slow release: rises immediately, falls one step per tick
    // only after the raw level has stayed lower for HOLD_TICKS ticks.
    always_comb begin
        level_d = level_q;
        hold_d  = hold_q;
        if (raw > level_q) begin
            level_d = raw;
            hold_d  = '0;
        end else if (game_tick) begin
            if (raw < level_q) begin
                if (hold_q >= HOLD_LAST) begin
                    level_d = level_q - 2'd1;
                    hold_d  = HOLD_MAX;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end else begin
                hold_d = '0;
            end
        end
        if (state_d == ST_IDLE) begin
            level_d = LVL_NONE;
            hold_d  = '0;
        end
    end

    always_comb begin
        step_d     = step_for(state_d, level_d);
        step_valid = game_tick && (state_q == ST_REEL || state_q == ST_COOL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= LVL_NONE;
            hold_q  <= '0;
            arm_q   <= '0;
            burst_q <= '0;
            cool_q  <= '0;
            step_q  <= STEP_NONE;
        end else begin
            level_q <= level_d;
            hold_q  <= hold_d;
            arm_q   <= arm_d;
            burst_q <= burst_d;
            cool_q  <= cool_d;
            step_q  <= step_d;
        end
    end

    assign step  = step_q;
    assign level = level_q;
    assign state = state_q;

endmodule
